operand_fetch: RTL and testbench

Issue stage between instruction decode and execute in the 64-bit core. It drives the register file read addresses and captures both source operands. Writeback results arriving in the same cycle are bypassed into the operands, because register file writes only land at the next clock edge. A busy-bit scoreboard stalls RAW/WAW hazards. Output goes through a one-entry valid/ready register into execute.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/operand_fetch_if.sv | 47 ++++
 rtl/reg_scoreboard.sv | 46 ++++
 rtl/operand_fetch.sv | 76 +++++++
 tb/tb_operand_fetch.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared core types: data width, register index width and the
// operand-source select used by the issue-stage bypass.
package cpu_pkg;
   localparam int XLEN      = 64;
   localparam int REG_IDX_W = 5;
   localparam int NUM_REGS  = 32;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   typedef enum logic [1:0] {
      OPSEL_ZERO,
      OPSEL_WB,
      OPSEL_RF
   } opsel_e;

   // x0 always reads as zero; a same-cycle writeback beats the register file.
   function automatic opsel_e opsel(input reg_idx_t idx, input logic wb_valid,
                                    input reg_idx_t wb_rd);
      if (idx == '0) return OPSEL_ZERO;
      else if (wb_valid && (wb_rd == idx)) return OPSEL_WB;
      else return OPSEL_RF;
   endfunction
endpackage

// File: rtl/operand_fetch_if.sv
// Issue-stage bus: decode input, register file read port, writeback
// bypass, execute output entry and the scoreboard debug view.
interface operand_fetch_if
   import cpu_pkg::*;
#(
   parameter int UOP_W = 32
);
   // Handshakes: a transfer occurs on a rising edge where valid && ready;
   // ready never depends on valid, and a held entry keeps its payload stable.
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   reg_idx_t         in_rs1;
   reg_idx_t         in_rs2;
   reg_idx_t         in_rd;
   logic             in_rd_wen;
   logic [UOP_W-1:0] in_uop;
   reg_idx_t         rf_r_reg1;
   reg_idx_t         rf_r_reg2;
   logic [XLEN-1:0]  rf_r_data1;
   logic [XLEN-1:0]  rf_r_data2;
   logic             wb_valid;
   reg_idx_t         wb_rd;
   logic [XLEN-1:0]  wb_data;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_rs1_val;
   logic [XLEN-1:0]  out_rs2_val;
   reg_idx_t         out_rd;
   logic             out_rd_wen;
   logic [UOP_W-1:0] out_uop;
   logic [NUM_REGS-1:0] dbg_busy;

   modport master (
      output flush, in_valid, in_rs1, in_rs2, in_rd, in_rd_wen, in_uop,
             rf_r_data1, rf_r_data2, wb_valid, wb_rd, wb_data, out_ready,
      input  in_ready, rf_r_reg1, rf_r_reg2, out_valid, out_rs1_val,
             out_rs2_val, out_rd, out_rd_wen, out_uop, dbg_busy
   );

   modport slave (
      input  flush, in_valid, in_rs1, in_rs2, in_rd, in_rd_wen, in_uop,
             rf_r_data1, rf_r_data2, wb_valid, wb_rd, wb_data, out_ready,
      output in_ready, rf_r_reg1, rf_r_reg2, out_valid, out_rs1_val,
             out_rs2_val, out_rd, out_rd_wen, out_uop, dbg_busy
   );
endinterface

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard. Lookups report a hazard only when the register is
// busy and not being written back in this same cycle.
module reg_scoreboard
   import cpu_pkg::*;
(
   input  logic                clk,
   input  logic                rstn,
   input  logic                flush,
   input  logic                set_en,
   input  reg_idx_t            set_idx,
   input  logic                clr_en,
   input  reg_idx_t            clr_idx,
   input  reg_idx_t            rs1,
   input  reg_idx_t            rs2,
   input  reg_idx_t            rd,
   input  logic                rd_wen,
   output logic                hz_rs1,
   output logic                hz_rs2,
   output logic                hz_rd,
   output logic [NUM_REGS-1:0] busy
);
   logic [NUM_REGS-1:0] busy_nxt;
   logic cov_rs1, cov_rs2, cov_rd;

   assign cov_rs1 = clr_en && (clr_idx == rs1) && (rs1 != '0);
   assign cov_rs2 = clr_en && (clr_idx == rs2) && (rs2 != '0);
   assign cov_rd  = clr_en && (clr_idx == rd)  && (rd  != '0);

   assign hz_rs1 = busy[rs1] && !cov_rs1;
   assign hz_rs2 = busy[rs2] && !cov_rs2;
   assign hz_rd  = rd_wen && busy[rd] && !cov_rd;

   // Set is applied after clear so a younger issue wins over an older writeback.
   always_comb begin
      busy_nxt = busy;
      if (clr_en) busy_nxt[clr_idx] = 1'b0;
      if (set_en) busy_nxt[set_idx] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)      busy <= '0;
      else if (flush) busy <= '0;
      else            busy <= busy_nxt;
   end
endmodule

// File: rtl/operand_fetch.sv
// Issue stage: register file read, writeback bypass, hazard stall and a
// one-entry output register into execute.
module operand_fetch
   import cpu_pkg::*;
(
   input logic            clk,
   input logic            rstn,
   operand_fetch_if.slave bus
);
   logic                hz_rs1, hz_rs2, hz_rd;
   logic                issue;
   logic [NUM_REGS-1:0] busy;
   logic [XLEN-1:0]     op1, op2;

   assign bus.rf_r_reg1 = bus.in_rs1;
   assign bus.rf_r_reg2 = bus.in_rs2;
   assign bus.dbg_busy  = busy;

   reg_scoreboard u_sb (
      .clk     (clk),
      .rstn    (rstn),
      .flush   (bus.flush),
      .set_en  (issue && bus.in_rd_wen),
      .set_idx (bus.in_rd),
      .clr_en  (bus.wb_valid),
      .clr_idx (bus.wb_rd),
      .rs1     (bus.in_rs1),
      .rs2     (bus.in_rs2),
      .rd      (bus.in_rd),
      .rd_wen  (bus.in_rd_wen),
      .hz_rs1  (hz_rs1),
      .hz_rs2  (hz_rs2),
      .hz_rd   (hz_rd),
      .busy    (busy)
   );

   assign bus.in_ready = (!bus.out_valid || bus.out_ready) && !hz_rs1 && !hz_rs2
                         && !hz_rd && !bus.flush;
   assign issue = bus.in_valid && bus.in_ready;

   function automatic logic [XLEN-1:0] pick(input opsel_e sel,
                                            input logic [XLEN-1:0] rf_data,
                                            input logic [XLEN-1:0] wb_data);
      case (sel)
         OPSEL_WB: return wb_data;
         OPSEL_RF: return rf_data;
         default:  return '0;
      endcase
   endfunction

   assign op1 = pick(opsel(bus.in_rs1, bus.wb_valid, bus.wb_rd), bus.rf_r_data1, bus.wb_data);
   assign op2 = pick(opsel(bus.in_rs2, bus.wb_valid, bus.wb_rd), bus.rf_r_data2, bus.wb_data);

   // Payload only loads on issue, so a held entry ignores later writebacks.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bus.out_valid   <= 1'b0;
         bus.out_rs1_val <= '0;
         bus.out_rs2_val <= '0;
         bus.out_rd      <= '0;
         bus.out_rd_wen  <= 1'b0;
         bus.out_uop     <= '0;
      end else if (bus.flush) begin
         bus.out_valid <= 1'b0;
      end else if (issue) begin
         bus.out_valid   <= 1'b1;
         bus.out_rs1_val <= op1;
         bus.out_rs2_val <= op2;
         bus.out_rd      <= bus.in_rd;
         bus.out_rd_wen  <= bus.in_rd_wen;
         bus.out_uop     <= bus.in_uop;
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: a vector table for operand selection
// plus hand-written hazard, backpressure, flush and reset sequences.
module tb_operand_fetch;
   import cpu_pkg::*;

   logic clk;
   logic rstn;
   operand_fetch_if bus ();

   operand_fetch dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural register file: writes land at the edge, reads are combinational.
   logic [XLEN-1:0] rf [NUM_REGS];
   logic            pre_we;
   reg_idx_t        pre_wa;
   logic [XLEN-1:0] pre_wd;

   always_ff @(posedge clk) begin
      if (bus.wb_valid && (bus.wb_rd != '0)) rf[bus.wb_rd] <= bus.wb_data;
      else if (pre_we)                        rf[pre_wa]    <= pre_wd;
   end

   always_comb begin
      bus.rf_r_data1 = rf[bus.rf_r_reg1];
      bus.rf_r_data2 = rf[bus.rf_r_reg2];
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic rf_load(input reg_idx_t a, input logic [XLEN-1:0] d);
      pre_we = 1'b1;
      pre_wa = a;
      pre_wd = d;
      @(posedge clk);
      #1;
      pre_we = 1'b0;
   endtask

   task automatic drive_instr(input reg_idx_t rs1, input reg_idx_t rs2, input reg_idx_t rd,
                              input logic wen, input logic [31:0] uop);
      bus.in_valid  = 1'b1;
      bus.in_rs1    = rs1;
      bus.in_rs2    = rs2;
      bus.in_rd     = rd;
      bus.in_rd_wen = wen;
      bus.in_uop    = uop;
   endtask

   task automatic drive_wb(input logic v, input reg_idx_t rd, input logic [XLEN-1:0] d);
      bus.wb_valid = v;
      bus.wb_rd    = rd;
      bus.wb_data  = d;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      reg_idx_t        rs1;
      reg_idx_t        rs2;
      logic            wbv;
      reg_idx_t        wbrd;
      logic [XLEN-1:0] wbd;
      logic [XLEN-1:0] exp1;
      logic [XLEN-1:0] exp2;
   } vec_t;

   vec_t vecs [7];

   initial begin
      vecs[0] = '{5'd1, 5'd2, 1'b0, 5'd0, 64'h0,    64'd5,    64'd7};
      vecs[1] = '{5'd0, 5'd1, 1'b0, 5'd0, 64'h0,    64'd0,    64'd5};
      vecs[2] = '{5'd6, 5'd7, 1'b1, 5'd6, 64'hAAAA, 64'hAAAA, 64'h2222};
      vecs[3] = '{5'd7, 5'd7, 1'b1, 5'd7, 64'h3333, 64'h3333, 64'h3333};
      vecs[4] = '{5'd0, 5'd0, 1'b1, 5'd0, 64'hFFFF, 64'd0,    64'd0};
      vecs[5] = '{5'd6, 5'd2, 1'b0, 5'd0, 64'h0,    64'hAAAA, 64'd7};
      vecs[6] = '{5'd2, 5'd6, 1'b1, 5'd2, 64'h77,   64'h77,   64'hAAAA};

      rstn = 1'b0;
      pre_we = 1'b0; pre_wa = '0; pre_wd = '0;
      bus.flush = 1'b0; bus.out_ready = 1'b1;
      bus.in_valid = 1'b0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_rd = '0;
      bus.in_rd_wen = 1'b0; bus.in_uop = '0;
      drive_wb(1'b0, '0, '0);

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_busy", 64'(bus.dbg_busy), 64'd0);
      chk("rst_rs1_val", bus.out_rs1_val, 64'd0);
      chk("rst_rs2_val", bus.out_rs2_val, 64'd0);
      chk("rst_rd", 64'(bus.out_rd), 64'd0);
      chk("rst_rd_wen", 64'(bus.out_rd_wen), 64'd0);
      chk("rst_uop", 64'(bus.out_uop), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      rstn = 1'b1;

      rf_load(5'd0, 64'hBAD);
      rf_load(5'd1, 64'd5);
      rf_load(5'd2, 64'd7);
      rf_load(5'd5, 64'h55);
      rf_load(5'd6, 64'h1111);
      rf_load(5'd7, 64'h2222);

      // Operand selection table, issued back to back
      for (int i = 0; i < 7; i++) begin
         drive_instr(vecs[i].rs1, vecs[i].rs2, 5'(i + 10), 1'b0, 32'hC0DE_0000 | 32'(i));
         drive_wb(vecs[i].wbv, vecs[i].wbrd, vecs[i].wbd);
         @(negedge clk);
         chk($sformatf("vec%0d_in_ready", i), 64'(bus.in_ready), 64'd1);
         next_cycle();
         bus.in_valid = 1'b0;
         drive_wb(1'b0, '0, '0);
         chk($sformatf("vec%0d_out_valid", i), 64'(bus.out_valid), 64'd1);
         chk($sformatf("vec%0d_rs1_val", i), bus.out_rs1_val, vecs[i].exp1);
         chk($sformatf("vec%0d_rs2_val", i), bus.out_rs2_val, vecs[i].exp2);
         chk($sformatf("vec%0d_rd", i), 64'(bus.out_rd), 64'(i + 10));
         chk($sformatf("vec%0d_uop", i), 64'(bus.out_uop), 64'(32'hC0DE_0000 | 32'(i)));
      end
      next_cycle();
      chk("drain_out_valid", 64'(bus.out_valid), 64'd0);
      rf_load(5'd2, 64'd7);

      // Basic issue with destination
      drive_instr(5'd1, 5'd2, 5'd3, 1'b1, 32'h1);
      next_cycle();
      bus.in_valid = 1'b0;
      chk("iss_out_valid", 64'(bus.out_valid), 64'd1);
      chk("iss_rs1_val", bus.out_rs1_val, 64'd5);
      chk("iss_rs2_val", bus.out_rs2_val, 64'd7);
      chk("iss_rd", 64'(bus.out_rd), 64'd3);
      chk("iss_rd_wen", 64'(bus.out_rd_wen), 64'd1);
      chk("iss_busy3", 64'(bus.dbg_busy), 64'h8);

      // Dependent instruction stalls until the producer's writeback, then bypasses
      drive_instr(5'd3, 5'd0, 5'd0, 1'b0, 32'h2);
      @(negedge clk);
      chk("dep_stall0", 64'(bus.in_ready), 64'd0);
      next_cycle();
      @(negedge clk);
      chk("dep_stall1", 64'(bus.in_ready), 64'd0);
      drive_wb(1'b1, 5'd3, 64'hDEAD);
      #1;
      chk("dep_ready_on_wb", 64'(bus.in_ready), 64'd1);
      next_cycle();
      bus.in_valid = 1'b0;
      drive_wb(1'b0, '0, '0);
      chk("dep_out_valid", 64'(bus.out_valid), 64'd1);
      chk("dep_rs1_bypass", bus.out_rs1_val, 64'hDEAD);
      chk("dep_busy_clear", 64'(bus.dbg_busy), 64'd0);

      // x0 source and x0 destination
      drive_instr(5'd0, 5'd1, 5'd0, 1'b1, 32'h3);
      @(negedge clk);
      chk("x0_ready", 64'(bus.in_ready), 64'd1);
      next_cycle();
      bus.in_valid = 1'b0;
      chk("x0_rs1_val", bus.out_rs1_val, 64'd0);
      chk("x0_rs2_val", bus.out_rs2_val, 64'd5);
      chk("x0_busy", 64'(bus.dbg_busy), 64'd0);

      // WAW: second writer of x4 waits for the first writeback
      drive_instr(5'd0, 5'd0, 5'd4, 1'b1, 32'h4);
      next_cycle();
      chk("waw_busy4", 64'(bus.dbg_busy), 64'h10);
      drive_instr(5'd1, 5'd2, 5'd4, 1'b1, 32'h5);
      @(negedge clk);
      chk("waw_stall", 64'(bus.in_ready), 64'd0);
      drive_wb(1'b1, 5'd4, 64'h44);
      #1;
      chk("waw_ready_on_wb", 64'(bus.in_ready), 64'd1);
      next_cycle();
      bus.in_valid = 1'b0;
      drive_wb(1'b0, '0, '0);
      chk("waw_out_rd", 64'(bus.out_rd), 64'd4);
      chk("waw_out_uop", 64'(bus.out_uop), 64'd5);
      chk("waw_busy4_kept", 64'(bus.dbg_busy), 64'h10);

      bus.flush = 1'b1;
      next_cycle();
      bus.flush = 1'b0;

      // Backpressure: held entry ignores writebacks to its sources
      bus.out_ready = 1'b0;
      drive_instr(5'd1, 5'd2, 5'd8, 1'b0, 32'hA);
      next_cycle();
      drive_instr(5'd2, 5'd1, 5'd0, 1'b0, 32'hB);
      drive_wb(1'b1, 5'd1, 64'h99);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("bp%0d_in_ready", c), 64'(bus.in_ready), 64'd0);
         chk($sformatf("bp%0d_out_valid", c), 64'(bus.out_valid), 64'd1);
         chk($sformatf("bp%0d_rs1_val", c), bus.out_rs1_val, 64'd5);
         chk($sformatf("bp%0d_uop", c), 64'(bus.out_uop), 64'hA);
         next_cycle();
      end
      drive_wb(1'b0, '0, '0);
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
      next_cycle();
      bus.in_valid = 1'b0;
      chk("bp_next_rs1", bus.out_rs1_val, 64'd7);
      chk("bp_next_rs2", bus.out_rs2_val, 64'h99);
      chk("bp_next_uop", 64'(bus.out_uop), 64'hB);

      // Flush with a held entry and busy x5, x9
      drive_instr(5'd0, 5'd0, 5'd5, 1'b1, 32'hC);
      next_cycle();
      drive_instr(5'd0, 5'd0, 5'd9, 1'b1, 32'hD);
      next_cycle();
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      chk("fl_busy_before", 64'(bus.dbg_busy), 64'h220);
      chk("fl_valid_before", 64'(bus.out_valid), 64'd1);
      bus.flush = 1'b1;
      drive_instr(5'd0, 5'd0, 5'd0, 1'b0, 32'hE);
      @(negedge clk);
      chk("fl_in_ready", 64'(bus.in_ready), 64'd0);
      next_cycle();
      bus.flush = 1'b0;
      bus.in_valid = 1'b0;
      chk("fl_out_valid", 64'(bus.out_valid), 64'd0);
      chk("fl_busy", 64'(bus.dbg_busy), 64'd0);
      bus.out_ready = 1'b1;
      drive_instr(5'd5, 5'd0, 5'd6, 1'b1, 32'hF);
      @(negedge clk);
      chk("fl_after_ready", 64'(bus.in_ready), 64'd1);
      next_cycle();
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      chk("fl_after_rs1", bus.out_rs1_val, 64'h55);
      chk("fl_after_valid", 64'(bus.out_valid), 64'd1);

      // Asynchronous reset mid-operation
      #2;
      rstn = 1'b0;
      #1;
      chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("arst_busy", 64'(bus.dbg_busy), 64'd0);
      chk("arst_rs1_val", bus.out_rs1_val, 64'd0);
      chk("arst_uop", 64'(bus.out_uop), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
